// File: rtl/vid_timing_gen.sv
// Video timing generator with built-in test patterns. Produces hs/vs/de, pixel
// coordinates and a 24-bit RGB pattern. Start and stop only take effect at frame boundaries.
module vid_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [1:0]    pattern_sel_i,
    input  logic [23:0]   color_i,
    output logic          hs_o,
    output logic          vs_o,
    output logic          de_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic [23:0]   rgb_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [CW-1:0] H_ACT_C   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_EOL_C   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] H_LAST_C  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] HS_BEG_C  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END_C  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_C   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_LAST_C  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] VS_BEG_C  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END_C  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BW_LAST_C = CW'(H_ACTIVE / 8 - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_r, state_nx_s;
    logic [CW-1:0] h_cnt_r, h_nx_s, v_cnt_r, v_nx_s;
    logic [CW-1:0] bar_cnt_r, bar_cnt_nx_s;
    logic [2:0]    bar_idx_r, bar_idx_nx_s;
    logic [1:0]    pat_r, pat_s;
    logic [23:0]   color_r, col_s, pix_s;
    logic          run_s, at_origin_s, h_last_s, v_last_s, active_s, hs_win_s, vs_win_s;
    logic          hs_s, vs_s, de_s, sof_s, eol_s;
    logic [CW-1:0] x_s, y_s;
    logic [23:0]   rgb_s;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    endfunction

    // Decode counter position; at (0,0) the incoming pattern is used directly so it is
    // in effect from the first pixel of the frame in which it is latched.
    always_comb begin
        run_s       = (state_r == ST_RUN);
        at_origin_s = (h_cnt_r == '0) && (v_cnt_r == '0);
        h_last_s    = (h_cnt_r == H_LAST_C);
        v_last_s    = (v_cnt_r == V_LAST_C);
        active_s    = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
        hs_win_s    = (h_cnt_r >= HS_BEG_C) && (h_cnt_r < HS_END_C);
        vs_win_s    = (v_cnt_r >= VS_BEG_C) && (v_cnt_r < VS_END_C);
        pat_s       = at_origin_s ? pattern_sel_i : pat_r;
        col_s       = at_origin_s ? color_i : color_r;
    end

    // Next-state for the run/idle FSM, raster counters and colour-bar counter.
    always_comb begin
        state_nx_s   = state_r;
        h_nx_s       = '0;
        v_nx_s       = '0;
        bar_cnt_nx_s = '0;
        bar_idx_nx_s = 3'd0;
        case (state_r)
            ST_IDLE: begin
                state_nx_s = en_i ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                state_nx_s = (h_last_s && v_last_s && !en_i) ? ST_IDLE : ST_RUN;
                h_nx_s     = h_last_s ? '0 : h_cnt_r + ONE_C;
                if (h_last_s) begin
                    v_nx_s = v_last_s ? '0 : v_cnt_r + ONE_C;
                end else begin
                    v_nx_s = v_cnt_r;
                end
                if (h_last_s) begin
                    bar_cnt_nx_s = '0;
                    bar_idx_nx_s = 3'd0;
                end else if (h_cnt_r < H_ACT_C) begin
                    if (bar_cnt_r == BW_LAST_C) begin
                        bar_cnt_nx_s = '0;
                        bar_idx_nx_s = bar_idx_r + 3'd1;
                    end else begin
                        bar_cnt_nx_s = bar_cnt_r + ONE_C;
                        bar_idx_nx_s = bar_idx_r;
                    end
                end else begin
                    bar_cnt_nx_s = bar_cnt_r;
                    bar_idx_nx_s = bar_idx_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Test-pattern pixel for the current counter position.
    always_comb begin
        pix_s = 24'h000000;
        case (pat_s)
            2'd0:    pix_s = bar_color(bar_idx_r);
            2'd1:    pix_s = {h_cnt_r[7:0], h_cnt_r[7:0], h_cnt_r[7:0]};
            2'd2:    pix_s = (h_cnt_r[5] ^ v_cnt_r[5]) ? 24'hFFFFFF : 24'h000000;
            2'd3:    pix_s = col_s;
            default: pix_s = 24'h000000;
        endcase
    end

    // Output values for the next clock; everything is forced inactive outside RUN/de.
    always_comb begin
        hs_s  = ~HS_POL;
        vs_s  = ~VS_POL;
        de_s  = 1'b0;
        sof_s = 1'b0;
        eol_s = 1'b0;
        x_s   = '0;
        y_s   = '0;
        rgb_s = 24'h000000;
        if (run_s) begin
            hs_s = hs_win_s ? HS_POL : ~HS_POL;
            vs_s = vs_win_s ? VS_POL : ~VS_POL;
            if (active_s) begin
                de_s  = 1'b1;
                sof_s = at_origin_s;
                eol_s = (h_cnt_r == H_EOL_C);
                x_s   = h_cnt_r;
                y_s   = v_cnt_r;
                rgb_s = pix_s;
            end else begin
                de_s = 1'b0;
            end
        end else begin
            hs_s = ~HS_POL;
            vs_s = ~VS_POL;
        end
    end

    // State, counters, per-frame pattern latch and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            h_cnt_r   <= '0;
            v_cnt_r   <= '0;
            bar_cnt_r <= '0;
            bar_idx_r <= 3'd0;
            pat_r     <= 2'd0;
            color_r   <= 24'h000000;
            hs_o      <= ~HS_POL;
            vs_o      <= ~VS_POL;
            de_o      <= 1'b0;
            sof_o     <= 1'b0;
            eol_o     <= 1'b0;
            x_o       <= '0;
            y_o       <= '0;
            rgb_o     <= 24'h000000;
        end else begin
            state_r   <= state_nx_s;
            h_cnt_r   <= h_nx_s;
            v_cnt_r   <= v_nx_s;
            bar_cnt_r <= bar_cnt_nx_s;
            bar_idx_r <= bar_idx_nx_s;
            if (run_s && at_origin_s) begin
                pat_r   <= pattern_sel_i;
                color_r <= color_i;
            end else begin
                pat_r   <= pat_r;
                color_r <= color_r;
            end
            hs_o  <= hs_s;
            vs_o  <= vs_s;
            de_o  <= de_s;
            sof_o <= sof_s;
            eol_o <= eol_s;
            x_o   <= x_s;
            y_o   <= y_s;
            rgb_o <= rgb_s;
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Randomised bench for vid_timing_gen (small raster): a frame-position reference model
// queues the expected outputs for every clock and a monitor compares them against the DUT.
module tb_vid_timing_gen;

    localparam int H_ACT = 16, H_FP = 2, H_SY = 3, H_BP = 3;
    localparam int V_ACT = 4,  V_FP = 1, V_SY = 2, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int F_TOT = H_TOT * V_TOT;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_i, en_i;
    logic [1:0]    pattern_sel_i;
    logic [23:0]   color_i;
    logic          hs_o, vs_o, de_o, sof_o, eol_o;
    logic [CW-1:0] x_o, y_o;
    logic [23:0]   rgb_o;

    vid_timing_gen #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
        .pattern_sel_i(pattern_sel_i), .color_i(color_i),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .sof_o(sof_o), .eol_o(eol_o),
        .x_o(x_o), .y_o(y_o), .rgb_o(rgb_o)
    );

    always #5 clk = ~clk;

    // {hs, vs, de, sof, eol, x, y, rgb}
    typedef logic [52:0] out_t;
    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    function automatic logic [23:0] bar_ref(input int x);
        int b;
        b = (x * 8) / H_ACT;
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected outputs for frame position pos (pols active-high, idle is all zero).
    function automatic out_t pix_ref(input int pos, input logic [1:0] pat, input logic [23:0] col);
        int h, v;
        logic hs, vs, de;
        logic [23:0] rgb;
        logic [CW-1:0] xv, yv;
        logic [7:0] xb;
        h  = pos % H_TOT;
        v  = pos / H_TOT;
        hs = (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SY);
        vs = (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SY);
        de = (h < H_ACT) && (v < V_ACT);
        xb = 8'(h);
        if (!de) rgb = 24'h000000;
        else if (pat == 2'd0) rgb = bar_ref(h);
        else if (pat == 2'd1) rgb = {xb, xb, xb};
        else if (pat == 2'd2) rgb = ((((h ^ v) >> 5) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        else rgb = col;
        xv = de ? CW'(h) : '0;
        yv = de ? CW'(v) : '0;
        return {hs, vs, de, (pos == 0), (de && h == H_ACT - 1), xv, yv, rgb};
    endfunction

    // Reference model: whole-frame position plus run flag, advanced on every clock edge.
    bit          m_run = 1'b0;
    int          m_pos = 0;
    logic [1:0]  m_pat = 2'd0;
    logic [23:0] m_col = 24'h0;
    always @(posedge clk) begin
        if (rst_i) begin
            exp_q.push_back('0);
            m_run = 1'b0;
            m_pos = 0;
        end else if (!m_run) begin
            exp_q.push_back('0);
            m_run = en_i;
        end else begin
            if (m_pos == 0) begin
                m_pat = pattern_sel_i;
                m_col = color_i;
            end
            exp_q.push_back(pix_ref(m_pos, m_pat, m_col));
            if (m_pos == F_TOT - 1 && !en_i) m_run = 1'b0;
            m_pos = (m_pos + 1) % F_TOT;
        end
    end

    // Monitor: one comparison per clock, sampled on the falling edge.
    always @(negedge clk) begin
        out_t act, e;
        cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {hs_o, vs_o, de_o, sof_o, eol_o, x_o, y_o, rgb_o};
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got hs%b vs%b de%b sof%b eol%b x%0d y%0d rgb%h required hs%b vs%b de%b sof%b eol%b x%0d y%0d rgb%h",
                         cyc, act[52], act[51], act[50], act[49], act[48], act[47:36], act[35:24], act[23:0],
                         e[52], e[51], e[50], e[49], e[48], e[47:36], e[35:24], e[23:0]);
            end
        end
    end

    initial begin
        rst_i = 1'b1; en_i = 1'b0; pattern_sel_i = 2'd0; color_i = 24'h0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        repeat (4) @(negedge clk);
        en_i = 1'b1;
        repeat (2 * F_TOT) @(negedge clk);
        // solid colour requested mid-frame, effective from the next frame
        pattern_sel_i = 2'd3; color_i = 24'h123456;
        repeat (F_TOT + 50) @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(20, 180)) @(negedge clk);
            pattern_sel_i = 2'($urandom_range(0, 3));
            color_i = 24'($urandom);
        end
        // drop run request mid-frame, then restart
        repeat ($urandom_range(H_TOT, 3 * H_TOT)) @(negedge clk);
        en_i = 1'b0;
        repeat (2 * F_TOT) @(negedge clk);
        en_i = 1'b1;
        repeat (F_TOT + 2 * H_TOT + 7) @(negedge clk);
        // reset pulse mid-frame
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        repeat (F_TOT) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(1, 260)) @(negedge clk);
            en_i = 1'($urandom_range(0, 1));
            pattern_sel_i = 2'($urandom_range(0, 3));
            color_i = 24'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                rst_i = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_i = 1'b0;
            end
        end
        en_i = 1'b0;
        repeat (F_TOT + 4) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected outputs never compared, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Video timing and test-pattern source at the head of the pixel pipeline.
- Generates hs/vs/de, pixel coordinates and a 24-bit RGB test pattern for every pixel.
- Downstream latency-alignment delay lines consume rgb_o and sync signals directly.
- Start/stop takes effect only on frame boundaries, so downstream never sees a truncated frame.

Parameters:
- H_ACTIVE, 640, active pixels per line; must be a multiple of 8.
- H_FP, 16, horizontal front porch, in clocks.
- H_SYNC, 96, hsync width, in clocks.
- H_BP, 48, horizontal back porch, in clocks.
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- HS_POL, 0, hsync active level (1 = active-high).
- VS_POL, 0, vsync active level (1 = active-high).
- CW, 12, coordinate counter width.

Ports:
- clk_i  input  1  pixel clock.
- rst_i  input  1  synchronous reset, active-high.
- en_i  input  1  run request; sampled at frame boundary only.
- pattern_sel_i  input  2  0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid.
- color_i  input  24  solid colour {R[23:16],G[15:8],B[7:0]}.
- hs_o  output  1  horizontal sync.
- vs_o  output  1  vertical sync.
- de_o  output  1  active-video enable.
- sof_o  output  1  one-clock pulse on pixel (0,0).
- eol_o  output  1  one-clock pulse on last active pixel of each line.
- x_o  output  CW  active pixel column; 0 outside de.
- y_o  output  CW  active line; 0 outside de.
- rgb_o  output  24  pattern pixel {R,G,B}; 0 outside de.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt runs 0..H_TOTAL-1; v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Line layout: active h_cnt < H_ACTIVE, then FP, then SYNC, then BP. Frame layout is the same in lines.
- hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vs edges therefore align with h_cnt=0.
- FSM states:
  - IDLE: counters held at (0,0); all outputs inactive.
  - IDLE->RUN: when en_i=1.
  - RUN->IDLE: at the final count (h=H_TOTAL-1, v=V_TOTAL-1) with en_i=0. Otherwise RUN wraps to (0,0) and continues.
  - en_i dropping mid-frame: the current frame completes normally.
- Output latency: all outputs are registered from the counter state one clock earlier.
  - en_i high in IDLE at cycle t -> counters (0,0) at t+1 -> de_o=1, sof_o=1, x_o=0, y_o=0 at t+2.
- Inactive levels: hs_o = ~HS_POL, vs_o = ~VS_POL; de_o, sof_o, eol_o, x_o, y_o and rgb_o are 0.
- Reset: all outputs take inactive levels and the FSM goes to IDLE on the first clock with rst_i=1, including mid-frame. The first frame after reset requires en_i.
- Pattern selection: pattern_sel_i and color_i are latched only when counters are (0,0) in RUN, so changes apply at frame granularity.
- Patterns:
  - Colour bars: bar width BW = H_ACTIVE/8, tracked by an incrementing bar counter (no divider). Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Grey ramp: R=G=B = x[7:0].
  - Checker: FFFFFF when x[5]^y[5], else 000000.
  - Solid: latched color_i.
- eol_o: asserted with de_o when x_o = H_ACTIVE-1.
- sof_o: asserted only with pixel (0,0).

Test Plan (small config: H 16/2/3/3 = H_TOTAL 24, V 4/1/2/1 = V_TOTAL 8, pols 1; frame = 192 clocks):
1. Reset release, en_i=1 at cycle t -> de_o first high at t+2 with sof_o=1, x_o=0, y_o=0; de_o high for 16 clocks with x_o 0..15, eol_o only at x_o=15; hs_o high clocks 18..20 of each line relative to de rise.
2. Vertical timing -> exactly 64 de_o clocks per frame; vs_o high for 48 clocks starting at line 5, h=0; sof_o period 192 clocks.
3. Colour bars, pattern_sel_i=0 -> rgb_o pairs per line: FFFFFF, FFFFFF, FFFF00, FFFF00, ..., 000000, 000000; rgb_o=0 whenever de_o=0.
4. pattern_sel_i changed 0->3 (color_i=123456) mid-frame -> current frame stays bars; next frame rgb_o=123456 on all 64 active pixels.
5. en_i dropped at line 1 -> frame completes (remaining de and vs intact), then outputs idle: hs_o=0, vs_o=0, de_o=0; re-asserting en_i restarts with latency 2.
6. rst_i pulsed at line 2, x=7 -> next clock all outputs inactive; with en_i=1 after release, sof_o fires 2 clocks after release.
